axi3_slave_mem_model: RTL and testbench

- Parametrised, synthesizable AXI3 slave with a word-addressed internal memory and independent read and write command queues.
- Replaces fixed-width, single-outstanding testbench responders with a reusable slave that stores write data and returns it on reads.
- Supports ID echo, INCR and FIXED bursts, protocol-error reporting and optional pseudo-random back-pressure.
- Sits behind the accelerator's AXI master in block-level and system benches.

---
 rtl/axi3_slv_pkg.sv | 18 +
 rtl/axi_cmd_fifo.sv | 48 ++++
 rtl/axi3_slave_mem_model.sv | 249 ++++++++++++++++++++++++
 tb/tb_axi3_slave_mem_model.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi3_slv_pkg.sv
// Shared encodings for the AXI3 slave memory model: burst types, response codes,
// FSM state enums and the throttle LFSR feedback taps.
package axi3_slv_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    // Fibonacci taps 16,14,13,11 expressed as a mask over lfsr[15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/axi_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO used for the AW and AR command queues.
module axi_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int LOG2  = 2
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 2 ** LOG2;

    logic [WIDTH-1:0] store [DEPTH];
    logic [LOG2-1:0]  wr_ptr, rd_ptr;
    logic [LOG2:0]    count;
    logic             do_push, do_pop;

    assign full    = (count == (LOG2 + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = store[rd_ptr];

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (do_push) store[wr_ptr] <= din;
    end

endmodule

// File: rtl/axi3_slave_mem_model.sv
// AXI3 slave backed by a word-addressed memory with independent AW/AR command queues.
// Define AXI_SLV_THROTTLE_EN to add LFSR-driven pseudo-random back-pressure.
module axi3_slave_mem_model
    import axi3_slv_pkg::*;
#(
    parameter int          DATA_WIDTH    = 64,
    parameter int          ADDR_WIDTH    = 32,
    parameter int          ID_WIDTH      = 6,
    parameter int          MEM_AW        = 12,
    parameter int          CMD_FIFO_LOG2 = 2,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [3:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ID_WIDTH-1:0]     ARID,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [3:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [ID_WIDTH-1:0]     RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic                    err_wlast,
    output logic [31:0]             wr_beat_count,
    output logic [31:0]             rd_beat_count
);
    // state  | meaning
    // W_IDLE | waiting for a queued AW command
    // W_DATA | accepting W beats until beat == len
    // W_RESP | presenting B until BREADY
    // R_IDLE | waiting for a queued AR command
    // R_DATA | presenting R beats until the last one is taken

    localparam int         STRB_W      = DATA_WIDTH / 8;
    localparam int         LSB         = $clog2(STRB_W);
    localparam logic [2:0] SIZE_NATIVE = 3'(LSB);
    localparam int         CMD_W       = ID_WIDTH + MEM_AW + 9;

    logic [DATA_WIDTH-1:0] mem [2**MEM_AW];
    logic live;
    logic aw_gate, ar_gate, w_gate, r_gate, b_gate;

`ifdef AXI_SLV_THROTTLE_EN
    logic [15:0] lfsr;
    always_ff @(posedge ACLK) begin
        if (!ARESETN) lfsr <= LFSR_SEED;
        else          lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
    assign aw_gate = lfsr[0];
    assign ar_gate = lfsr[1];
    assign w_gate  = lfsr[2];
    assign r_gate  = lfsr[3];
    assign b_gate  = lfsr[4];
`else
    assign aw_gate = 1'b1;
    assign ar_gate = 1'b1;
    assign w_gate  = 1'b1;
    assign r_gate  = 1'b1;
    assign b_gate  = 1'b1;
`endif

    // Keeps the READY outputs low during the reset cycle itself
    always_ff @(posedge ACLK) live <= ARESETN;

    logic             aw_push, aw_pop, aw_full, aw_empty;
    logic             ar_push, ar_pop, ar_full, ar_empty;
    logic [CMD_W-1:0] aw_cmd, ar_cmd;

    assign AWREADY = live && !aw_full && aw_gate;
    assign ARREADY = live && !ar_full && ar_gate;
    assign aw_push = AWVALID && AWREADY;
    assign ar_push = ARVALID && ARREADY;

    axi_cmd_fifo #(.WIDTH(CMD_W), .LOG2(CMD_FIFO_LOG2)) u_aw_fifo (
        .ACLK(ACLK), .ARESETN(ARESETN), .push(aw_push),
        .din({AWID, AWADDR[MEM_AW+LSB-1:LSB], AWLEN, AWSIZE, AWBURST}),
        .pop(aw_pop), .dout(aw_cmd), .full(aw_full), .empty(aw_empty)
    );

    axi_cmd_fifo #(.WIDTH(CMD_W), .LOG2(CMD_FIFO_LOG2)) u_ar_fifo (
        .ACLK(ACLK), .ARESETN(ARESETN), .push(ar_push),
        .din({ARID, ARADDR[MEM_AW+LSB-1:LSB], ARLEN, ARSIZE, ARBURST}),
        .pop(ar_pop), .dout(ar_cmd), .full(ar_full), .empty(ar_empty)
    );

    wr_state_t           w_state, w_next;
    logic [MEM_AW-1:0]   w_idx;
    logic [3:0]          w_beat, w_len;
    logic [1:0]          w_burst;
    logic [ID_WIDTH-1:0] w_id;
    logic                w_size_err, w_last_err, w_fire, w_final, w_last_bad, b_hold;

    assign w_fire     = WVALID && WREADY;
    assign w_final    = (w_beat == w_len);
    assign w_last_bad = (WLAST != w_final);

    always_comb begin
        w_next = w_state;
        aw_pop = 1'b0;
        WREADY = 1'b0;
        BVALID = 1'b0;
        case (w_state)
            W_IDLE: if (!aw_empty) begin
                aw_pop = 1'b1;
                w_next = W_DATA;
            end
            W_DATA: begin
                WREADY = w_gate;
                if (WVALID && w_gate && w_final) w_next = W_RESP;
            end
            W_RESP: begin
                BVALID = b_gate || b_hold;
                if (BVALID && BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            w_state       <= W_IDLE;
            w_idx         <= '0;
            w_beat        <= '0;
            w_len         <= '0;
            w_burst       <= BURST_INCR;
            w_id          <= '0;
            w_size_err    <= 1'b0;
            w_last_err    <= 1'b0;
            b_hold        <= 1'b0;
            BID           <= '0;
            BRESP         <= RESP_OKAY;
            err_wlast     <= 1'b0;
            wr_beat_count <= '0;
        end else begin
            w_state <= w_next;
            b_hold  <= BVALID && !BREADY;
            if (aw_pop) begin
                w_id       <= aw_cmd[CMD_W-1 -: ID_WIDTH];
                w_idx      <= aw_cmd[MEM_AW+8:9];
                w_len      <= aw_cmd[8:5];
                w_size_err <= (aw_cmd[4:2] != SIZE_NATIVE);
                w_burst    <= aw_cmd[1:0];
                w_beat     <= '0;
                w_last_err <= 1'b0;
            end
            if (w_fire) begin
                wr_beat_count <= wr_beat_count + 1'b1;
                w_beat        <= w_beat + 1'b1;
                if (w_burst != BURST_FIXED) w_idx <= w_idx + 1'b1;
                if (w_last_bad) begin
                    err_wlast  <= 1'b1;
                    w_last_err <= 1'b1;
                end
                if (w_final) begin
                    BID   <= w_id;
                    BRESP <= (w_size_err || w_last_err || w_last_bad) ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESETN && w_fire && !w_size_err) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (WSTRB[b]) mem[w_idx][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
    end

    rd_state_t         r_state, r_next;
    logic [MEM_AW-1:0] r_idx;
    logic [3:0]        r_beat, r_len;
    logic [1:0]        r_burst;
    logic              r_size_err, r_hold, r_fire;

    assign r_fire = RVALID && RREADY;
    assign RDATA  = (r_state == R_DATA) ? mem[r_idx] : '0;
    assign RLAST  = (r_state == R_DATA) && (r_beat == r_len);
    assign RRESP  = ((r_state == R_DATA) && r_size_err) ? RESP_SLVERR : RESP_OKAY;

    always_comb begin
        r_next = r_state;
        ar_pop = 1'b0;
        RVALID = 1'b0;
        case (r_state)
            R_IDLE: if (!ar_empty) begin
                ar_pop = 1'b1;
                r_next = R_DATA;
            end
            R_DATA: begin
                RVALID = r_gate || r_hold;
                if (RVALID && RREADY && (r_beat == r_len)) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state       <= R_IDLE;
            r_idx         <= '0;
            r_beat        <= '0;
            r_len         <= '0;
            r_burst       <= BURST_INCR;
            RID           <= '0;
            r_size_err    <= 1'b0;
            r_hold        <= 1'b0;
            rd_beat_count <= '0;
        end else begin
            r_state <= r_next;
            r_hold  <= RVALID && !RREADY;
            if (ar_pop) begin
                RID        <= ar_cmd[CMD_W-1 -: ID_WIDTH];
                r_idx      <= ar_cmd[MEM_AW+8:9];
                r_len      <= ar_cmd[8:5];
                r_size_err <= (ar_cmd[4:2] != SIZE_NATIVE);
                r_burst    <= ar_cmd[1:0];
                r_beat     <= '0;
            end
            if (r_fire) begin
                rd_beat_count <= rd_beat_count + 1'b1;
                r_beat        <= r_beat + 1'b1;
                if (r_burst != BURST_FIXED) r_idx <= r_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi3_slave_mem_model.sv
// Bench for axi3_slave_mem_model: directed bursts against a word-level memory model
// with in-order B/R scoreboards checked every negedge.
`timescale 1ns/1ps
module tb_axi3_slave_mem_model;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [5:0]  AWID = '0, ARID = '0, BID, RID;
    logic [31:0] AWADDR = '0, ARADDR = '0;
    logic [3:0]  AWLEN = '0, ARLEN = '0;
    logic [2:0]  AWSIZE = '0, ARSIZE = '0;
    logic [1:0]  AWBURST = '0, ARBURST = '0, BRESP, RRESP;
    logic        AWVALID = 1'b0, AWREADY, WLAST = 1'b0, WVALID = 1'b0, WREADY;
    logic [63:0] WDATA = '0, RDATA;
    logic [7:0]  WSTRB = '0;
    logic        BVALID, BREADY = 1'b1, ARVALID = 1'b0, ARREADY;
    logic        RLAST, RVALID, RREADY = 1'b1, err_wlast;
    logic [31:0] wr_beat_count, rd_beat_count;

    always #5 ACLK = ~ACLK;

    axi3_slave_mem_model dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .err_wlast(err_wlast), .wr_beat_count(wr_beat_count), .rd_beat_count(rd_beat_count)
    );

    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Word-level model: 4096 words of 8 bytes, upper address bits ignored
    logic [63:0] mdl_mem [4096];

    typedef struct { logic [5:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [5:0] id; logic [63:0] data; logic [1:0] resp; logic last; } r_exp_t;
    b_exp_t exp_b [$];
    r_exp_t exp_r [$];
    logic [63:0] rd_log [$];
    logic [1:0]  last_bresp = '0;

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr >> 3) % 4096);
    endfunction

    function automatic int next_word(input int w, input logic [1:0] burst);
        return (burst == FIXED) ? w : (w + 1) % 4096;
    endfunction

    logic        r_stall = 1'b0, b_stall = 1'b0;
    logic [63:0] s_rdata;
    logic        s_rlast;
    logic [5:0]  s_rid, s_bid;
    logic [1:0]  s_rresp, s_bresp;

    always @(negedge ACLK) begin
        if (!ARESETN) begin
            r_stall <= 1'b0;
            b_stall <= 1'b0;
        end else begin
            if (r_stall) begin
                check("r_hold_valid", RVALID, 1);
                check("r_hold_data", RDATA, s_rdata);
                check("r_hold_last", RLAST, s_rlast);
                check("r_hold_id", RID, s_rid);
                check("r_hold_resp", RRESP, s_rresp);
            end
            if (b_stall) begin
                check("b_hold_valid", BVALID, 1);
                check("b_hold_id", BID, s_bid);
                check("b_hold_resp", BRESP, s_bresp);
            end
            if (RVALID && RREADY) begin
                if (exp_r.size() == 0) check("r_unexpected_valid", RVALID, 0);
                else begin
                    r_exp_t e;
                    e = exp_r.pop_front();
                    check("rid", RID, e.id);
                    check("rdata", RDATA, e.data);
                    check("rresp", RRESP, e.resp);
                    check("rlast", RLAST, e.last);
                    rd_log.push_back(RDATA);
                end
            end
            if (BVALID && BREADY) begin
                if (exp_b.size() == 0) check("b_unexpected_valid", BVALID, 0);
                else begin
                    b_exp_t e;
                    e = exp_b.pop_front();
                    check("bid", BID, e.id);
                    check("bresp", BRESP, e.resp);
                    last_bresp <= BRESP;
                end
            end
            r_stall <= RVALID && !RREADY;
            b_stall <= BVALID && !BREADY;
            s_rdata <= RDATA; s_rlast <= RLAST; s_rid <= RID; s_rresp <= RRESP;
            s_bid <= BID; s_bresp <= BRESP;
        end
    end

    task automatic aw_send(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input logic [2:0] size);
        int t = 0;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        @(negedge ACLK);
        while (!AWREADY && t < 200) begin t++; @(negedge ACLK); end
        check("aw_ready", AWREADY, 1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
    endtask

    task automatic w_beats(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input logic [2:0] size, input logic [63:0] base,
                           input logic [7:0] strb, input int bad_last, input int nbeats);
        int  w   = word_of(addr);
        bit  err = (size != 3'd3);
        for (int i = 0; i < nbeats; i++) begin
            int t = 0;
            WDATA  = base + 64'(i);
            WSTRB  = strb;
            WLAST  = (bad_last >= 0) ? (i == bad_last) : (i == int'(len));
            WVALID = 1'b1;
            @(negedge ACLK);
            while (!WREADY && t < 200) begin t++; @(negedge ACLK); end
            check("w_ready", WREADY, 1);
            if (WLAST != (i == int'(len))) err = 1'b1;
            if (size == 3'd3)
                for (int b = 0; b < 8; b++)
                    if (strb[b]) mdl_mem[w][8*b +: 8] = WDATA[8*b +: 8];
            w = next_word(w, burst);
            @(posedge ACLK); #1;
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
        if (nbeats == int'(len) + 1) begin
            b_exp_t e;
            e.id = id;
            e.resp = err ? 2'b10 : 2'b00;
            exp_b.push_back(e);
        end
    endtask

    task automatic write_burst(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                               input logic [1:0] burst, input logic [2:0] size, input logic [63:0] base,
                               input logic [7:0] strb, input int bad_last);
        aw_send(id, addr, len, burst, size);
        w_beats(id, addr, len, burst, size, base, strb, bad_last, int'(len) + 1);
    endtask

    task automatic ar_send(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input logic [2:0] size);
        int w = word_of(addr);
        int t = 0;
        for (int i = 0; i <= int'(len); i++) begin
            r_exp_t e;
            e.id = id; e.data = mdl_mem[w]; e.resp = (size != 3'd3) ? 2'b10 : 2'b00;
            e.last = (i == int'(len));
            exp_r.push_back(e);
            w = next_word(w, burst);
        end
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        @(negedge ACLK);
        while (!ARREADY && t < 200) begin t++; @(negedge ACLK); end
        check("ar_ready", ARREADY, 1);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((exp_r.size() + exp_b.size()) != 0 && t < 500) begin
            @(posedge ACLK); #1;
            t++;
        end
        check(name, 64'(exp_r.size() + exp_b.size()), 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_awready"}, AWREADY, 0);
        check({tag, "_arready"}, ARREADY, 0);
        check({tag, "_wready"}, WREADY, 0);
        check({tag, "_bvalid"}, BVALID, 0);
        check({tag, "_rvalid"}, RVALID, 0);
        check({tag, "_rlast"}, RLAST, 0);
        check({tag, "_rdata"}, RDATA, 0);
        check({tag, "_bid"}, BID, 0);
        check({tag, "_bresp"}, BRESP, 0);
        check({tag, "_rid"}, RID, 0);
        check({tag, "_rresp"}, RRESP, 0);
        check({tag, "_err_wlast"}, err_wlast, 0);
        check({tag, "_wr_cnt"}, wr_beat_count, 0);
        check({tag, "_rd_cnt"}, rd_beat_count, 0);
    endtask

    task automatic do_reset(input string tag);
        ARESETN = 1'b0;
        AWVALID = 1'b0; WVALID = 1'b0; WLAST = 1'b0; ARVALID = 1'b0;
        exp_r.delete();
        exp_b.delete();
        repeat (3) @(posedge ACLK);
        #1;
        check_reset(tag);
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        do_reset("init");

        // Single write then read, with AW-to-WREADY latency
        aw_send(6'h05, 32'h100, 4'd3, INCR, 3'd3);
        @(negedge ACLK); check("lat_wready_n1", WREADY, 0);
        @(negedge ACLK); check("lat_wready_n2", WREADY, 1);
        @(posedge ACLK); #1;
        w_beats(6'h05, 32'h100, 4'd3, INCR, 3'd3, 64'hA0, 8'hFF, -1, 4);
        wait_idle("t1_b_drain");
        check("t1_mdl_w0", mdl_mem[32], 64'hA0);
        check("t1_mdl_w3", mdl_mem[35], 64'hA3);
        rd_log.delete();
        ar_send(6'h09, 32'h100, 4'd3, INCR, 3'd3);
        wait_idle("t1_r_drain");
        check("t1_rlog_len", 64'(rd_log.size()), 4);
        for (int i = 0; i < 4; i++) check("t1_rdata_lit", rd_log[i], 64'hA0 + 64'(i));
        check("t1_wr_cnt", wr_beat_count, 4);
        check("t1_rd_cnt", rd_beat_count, 4);

        // Partial strobe merge
        write_burst(6'h01, 32'h200, 4'd0, INCR, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, -1);
        write_burst(6'h02, 32'h200, 4'd0, INCR, 3'd3, 64'h1122_3344_5566_7788, 8'h0F, -1);
        wait_idle("t2_b_drain");
        rd_log.delete();
        ar_send(6'h03, 32'h200, 4'd0, INCR, 3'd3);
        wait_idle("t2_r_drain");
        check("t2_merge_lit", rd_log[0], 64'hFFFF_FFFF_5566_7788);

        // Early WLAST, with B held off by BREADY
        BREADY = 1'b0;
        write_burst(6'h07, 32'h300, 4'd3, INCR, 3'd3, 64'hC0, 8'hFF, 1);
        repeat (3) @(posedge ACLK);
        #1;
        check("t3_bvalid_wait", BVALID, 1);
        BREADY = 1'b1;
        wait_idle("t3_b_drain");
        check("t3_bresp_lit", last_bresp, 2'b10);
        check("t3_err_wlast", err_wlast, 1);
        check("t3_wr_cnt", wr_beat_count, 10);

        // Five AW with no W data: four queued behind the one in flight
        for (int i = 1; i <= 5; i++)
            aw_send(6'(i), 32'h400 + 32'(8 * i), 4'd0, INCR, 3'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK); check("t4_awready_full", AWREADY, 0);
        end
        @(posedge ACLK); #1;
        w_beats(6'd1, 32'h408, 4'd0, INCR, 3'd3, 64'h41, 8'hFF, -1, 1);
        wait_idle("t4_b1_drain");
        t = 0;
        while (!AWREADY && t < 20) begin @(posedge ACLK); #1; t++; end
        check("t4_awready_free", AWREADY, 1);
        for (int i = 2; i <= 5; i++)
            w_beats(6'(i), 32'h400 + 32'(8 * i), 4'd0, INCR, 3'd3, 64'h40 + 64'(i), 8'hFF, -1, 1);
        wait_idle("t4_b_drain");
        check("t4_err_wlast_sticky", err_wlast, 1);

        // FIXED burst and index wrap-around
        write_burst(6'h11, 32'h38, 4'd3, FIXED, 3'd3, 64'hD0, 8'hFF, -1);
        write_burst(6'h12, 32'h7FF8, 4'd1, INCR, 3'd3, 64'hE0, 8'hFF, -1);
        wait_idle("t5_b_drain");
        rd_log.delete();
        ar_send(6'h13, 32'h38, 4'd0, INCR, 3'd3);
        ar_send(6'h14, 32'h7FF8, 4'd1, INCR, 3'd3);
        ar_send(6'h15, 32'hFFFF_0000, 4'd0, INCR, 3'd3);
        wait_idle("t5_r_drain");
        check("t5_fixed_lit", rd_log[0], 64'hD3);
        check("t5_wrap_top_lit", rd_log[1], 64'hE0);
        check("t5_wrap_zero_lit", rd_log[2], 64'hE1);
        check("t5_upper_ign_lit", rd_log[3], 64'hE1);

        // Non-native size: no memory update, SLVERR on B and R
        write_burst(6'h16, 32'h500, 4'd0, INCR, 3'd3, 64'h5A5A, 8'hFF, -1);
        write_burst(6'h17, 32'h500, 4'd0, INCR, 3'd2, 64'hDEAD, 8'hFF, -1);
        wait_idle("t6_b_drain");
        check("t6_bresp_lit", last_bresp, 2'b10);
        rd_log.delete();
        ar_send(6'h18, 32'h500, 4'd0, INCR, 3'd3);
        ar_send(6'h19, 32'h500, 4'd0, INCR, 3'd2);
        wait_idle("t6_r_drain");
        check("t6_keep_lit", rd_log[0], 64'h5A5A);

        // RREADY low for 5 cycles mid-burst
        rd_log.delete();
        ar_send(6'h20, 32'h100, 4'd3, INCR, 3'd3);
        t = 0;
        while (rd_log.size() < 2 && t < 50) begin @(posedge ACLK); #1; t++; end
        check("t7_two_beats", 64'(rd_log.size()), 2);
        RREADY = 1'b0;
        repeat (5) @(posedge ACLK);
        #1;
        RREADY = 1'b1;
        wait_idle("t7_r_drain");

        // Reset during an open read and an open write burst
        RREADY = 1'b0;
        ar_send(6'h21, 32'h100, 4'd3, INCR, 3'd3);
        aw_send(6'h22, 32'h600, 4'd3, INCR, 3'd3);
        w_beats(6'h22, 32'h600, 4'd3, INCR, 3'd3, 64'hF0, 8'hFF, -1, 2);
        t = 0;
        while (!RVALID && t < 50) begin @(posedge ACLK); #1; t++; end
        check("t8_rvalid_before", RVALID, 1);
        do_reset("mid");
        RREADY = 1'b1;
        BREADY = 1'b1;
        repeat (10) @(posedge ACLK);
        #1;
        check("t8_no_stale_r", RVALID, 0);
        check("t8_no_stale_b", BVALID, 0);
        rd_log.delete();
        ar_send(6'h23, 32'h100, 4'd3, INCR, 3'd3);
        wait_idle("t8_r_drain");
        check("t8_retained_lit", rd_log[0], 64'hA0);
        check("t8_rd_cnt", rd_beat_count, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
